// File: rtl/cypher_input_fifo.sv
// Circular input FIFO feeding the cypher detector: valid/ready on the source side,
// pop-on-read toward the detector, with registered decimal-digit decode of each popped character.
module cypher_input_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   input  logic                     read,
   output logic                     stop,
   output logic [WIDTH-1:0]         data_out,
   output logic [3:0]               digit,
   output logic                     check,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    rp_q, rp_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] data_out_q;
   logic [3:0]       digit_q;
   logic             check_q;
   logic             overflow_q;

   logic             full, empty, push, pop;
   logic [WIDTH-1:0] rd_char;
   logic             rd_is_digit;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   // Ready comes only from occupancy, so a pop never opens a slot in the same cycle.
   assign push  = in_valid && !full;
   assign pop   = read && !empty;

   assign rd_char     = mem_q[rp_q];
   assign rd_is_digit = (rd_char >= WIDTH'(8'h30)) && (rd_char <= WIDTH'(8'h39));

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: the storage array has no reset; its contents are unreachable until written, and leaving it out keeps it a plain register file.
   always_ff @(posedge clock) begin
      if (push) mem_q[wp_q] <= in_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         data_out_q <= '0;
         digit_q    <= '0;
         check_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         if (pop) begin
            data_out_q <= rd_char;
            check_q    <= rd_is_digit;
            digit_q    <= rd_is_digit ? rd_char[3:0] : 4'd0;
         end
         if (in_valid && full) overflow_q <= 1'b1;
      end
   end

   assign in_ready = !full;
   assign stop     = empty;
   assign data_out = data_out_q;
   assign digit    = digit_q;
   assign check    = check_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_cypher_input_fifo.sv
// Self-checking bench for cypher_input_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_cypher_input_fifo;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             read;
   logic             stop;
   logic [WIDTH-1:0] data_out;
   logic [3:0]       digit;
   logic             check;
   logic [3:0]       count;
   logic             overflow;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] q[$];
   logic [7:0] m_data;
   logic       m_check;
   logic [3:0] m_digit;
   logic       m_ovf;

   cypher_input_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .read     (read),
      .stop     (stop),
      .data_out (data_out),
      .digit    (digit),
      .check    (check),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_data  = 8'h00;
      m_check = 1'b0;
      m_digit = 4'd0;
      m_ovf   = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".count"},    32'(count),    32'(q.size()));
      chk({tag, ".stop"},     32'(stop),     32'(q.size() == 0));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
      chk({tag, ".data_out"}, 32'(data_out), 32'(m_data));
      chk({tag, ".check"},    32'(check),    32'(m_check));
      chk({tag, ".digit"},    32'(digit),    32'(m_digit));
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   // Apply one cycle of stimulus, advance the model by the behavioural rules, then compare.
   task automatic cyc(input logic v, input logic [7:0] d, input logic r, input string tag);
      bit was_full, was_empty;
      logic [7:0] c;
      in_valid = v;
      in_data  = d;
      read     = r;
      @(posedge clock);
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (r && !was_empty) begin
         c       = q.pop_front();
         m_data  = c;
         m_check = (c >= 8'h30 && c <= 8'h39);
         m_digit = m_check ? 4'(c - 8'h30) : 4'd0;
      end
      if (v && !was_full) q.push_back(d);
      if (v && was_full) m_ovf = 1'b1;
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [7:0] d;
      int pv, pr;
      in_valid = 1'b0;
      in_data  = '0;
      read     = 1'b0;
      reset    = 1'b1;
      model_reset();
      #12;
      check_all("reset");
      reset = 1'b0;

      // Digit '7' with read held high: push first, pop on the following edge
      cyc(1'b1, 8'h37, 1'b1, "push7");
      chk("push7.stop_low", 32'(stop), 32'd0);
      cyc(1'b0, 8'h00, 1'b1, "pop7");
      chk("pop7.digit", 32'(digit), 32'd7);

      // Non-digit characters, including both neighbours of the digit range
      cyc(1'b1, 8'h41, 1'b0, "pushA");
      cyc(1'b0, 8'h00, 1'b1, "popA");
      cyc(1'b1, 8'h2F, 1'b0, "push2F");
      cyc(1'b0, 8'h00, 1'b1, "pop2F");
      cyc(1'b1, 8'h3A, 1'b0, "push3A");
      cyc(1'b0, 8'h00, 1'b1, "pop3A");
      chk("pop3A.check", 32'(check), 32'd0);
      cyc(1'b1, 8'h39, 1'b0, "push39");
      cyc(1'b0, 8'h00, 1'b1, "pop39");
      cyc(1'b0, 8'h00, 1'b1, "read_empty");

      // Fill, overflow, drain in order
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, "fill");
      chk("fill.in_ready", 32'(in_ready), 32'd0);
      cyc(1'b1, 8'h38, 1'b0, "offer_full");
      chk("offer_full.overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, "drain");
      chk("drain.last", 32'(data_out), 32'h37);

      // Wrap-around with 3 in flight
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, "prime");
      for (int i = 3; i < 20; i++) cyc(1'b1, 8'(8'h50 + i), 1'b1, "stream");
      chk("stream.count", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, "flush");

      // Push and read together while empty: push only, data_out held
      cyc(1'b1, 8'h35, 1'b1, "both_empty");
      chk("both_empty.data_out", 32'(data_out), 32'h52 + 32'd17);
      // Push and read together while full: pop only, offer dropped
      for (int i = 0; i < DEPTH - 1; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, "refill");
      cyc(1'b1, 8'h99, 1'b1, "both_full");
      chk("both_full.count", 32'(count), 32'd7);

      // Asynchronous reset between edges with 5 entries held
      for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, "empty_out");
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0, "five");
      chk("five.count", 32'(count), 32'd5);
      in_valid = 1'b0;
      read     = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_all("async_reset");
      #1 reset = 1'b0;
      cyc(1'b1, 8'h34, 1'b0, "post_reset_push");
      cyc(1'b1, 8'h42, 1'b1, "post_reset_both");
      chk("post_reset.first", 32'(data_out), 32'h34);
      cyc(1'b0, 8'h00, 1'b1, "post_reset_pop");

      // Randomized traffic in phases that favour filling, draining and streaming
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0:       begin pv = 80; pr = 30; end
            1:       begin pv = 30; pr = 80; end
            2:       begin pv = 60; pr = 60; end
            default: begin pv = 90; pr = 90; end
         endcase
         for (int i = 0; i < 100; i++) begin
            d = $urandom_range(0, 1) != 0 ? 8'(8'h30 + $urandom_range(0, 9))
                                          : 8'($urandom_range(0, 255));
            cyc($urandom_range(0, 99) < pv, d, $urandom_range(0, 99) < pr, "random");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cypher_input_fifo.md
# cypher_input_fifo

Input buffer stage that sits directly upstream of the cypher detector controller and datapath. It accepts characters from the character source with a valid/ready handshake and stores them in a circular FIFO. Characters are handed one at a time to the detector on its `read` strobe. The block also drives the detector's `stop` input (no data available) and its `check` input (the popped character is a decimal cypher digit).

## Interface
Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- WIDTH, 8, character width in bits; minimum 8.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately, independent of clock.
- in_valid  in  1  source presents a character.
- in_data  in  WIDTH  character from the source.
- in_ready  out  1  FIFO can accept a character; equals not full.
- read  in  1  pop request from the detector controller.
- stop  out  1  FIFO empty; combinational from the occupancy count.
- data_out  out  WIDTH  last popped character (registered).
- digit  out  4  `data_out[3:0]` when `check` is 1, otherwise 0 (registered).
- check  out  1  last popped character is ASCII '0'..'9' (0x30..0x39) (registered).
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a character was offered while the FIFO was full.

## Operation
- Storage: DEPTH x WIDTH register array with write pointer `wp`, read pointer `rp` and occupancy `count`.
  - Pointers are clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - `full` is `count == DEPTH`; `empty` is `count == 0`.
- Push:
  - Occurs when `in_valid && in_ready`.
  - Writes `in_data` into `mem[wp]`, then increments `wp`.
- Pop:
  - Occurs when `read && !empty`.
  - Loads `data_out <= mem[rp]`, increments `rp`, and updates `check` and `digit` from the same entry in the same cycle.
- Count update: +1 on push only; -1 on pop only; unchanged when both or neither occur.
- Simultaneous push and pop:
  - When 0 < count < DEPTH, both are performed and `count` is unchanged.
  - When empty, only the push occurs. The pop is suppressed (`stop`=1), so the new character is not bypassed to `data_out`.
  - When full, only the pop occurs. `in_ready`=0 during that cycle even though a slot frees at the edge; no combinational ready-from-read path.
- Rejected offer: `in_valid && !in_ready` drops the character and sets `overflow`=1. `overflow` clears only on reset.
- `read` while empty: no state change; `data_out`, `check` and `digit` hold their previous values.
- The controller asserts `read` in its IDLE and READ states. After reset the FIFO is empty, so the IDLE-cycle `read` has no effect unless a push has already completed.
- `check` and `digit` are registered with the popped character and never change without a pop.

## Timing
- Reset values: `in_ready`=1, `stop`=1, `data_out`=0, `digit`=0, `check`=0, `count`=0, `overflow`=0, `wp`=`rp`=0. Memory contents are don't-care.
- Push-to-visible latency:
  - A push at edge N makes `count`=1 and `stop`=0 after edge N.
  - The earliest pop is at edge N+1.
  - `data_out` is valid after edge N+1, i.e. during the controller's DECIDE cycle.
- Pop at edge N: `data_out`, `check` and `digit` are valid from after edge N until the next pop.
- Throughput: one push and one pop per cycle.
- Reset mid-operation: all stored characters are discarded and outputs return to their reset values asynchronously. The first edge after reset deassertion behaves as if starting from empty.

## Test plan
- Reset, then push "7" (0x37) with `read` held high: `stop` drops one cycle after the push. At the following edge `data_out`=0x37, `check`=1, `digit`=7, `count`=0, `stop`=1.
- Push "A" (0x41), then pop: `data_out`=0x41, `check`=0, `digit`=0. Also check 0x2F and 0x3A, which give `check`=0.
- Push 8 characters 0x30..0x37 with no reads: `count`=8, `in_ready`=0. Offer 0x38: it is dropped and `overflow`=1. Pop all 8: order is 0x30..0x37, then `stop`=1, and `overflow` stays 1.
- Wrap-around: push and pop continuously for 20 characters with 3 kept in flight. Output order must equal input order and `count` stays at 3.
- Edge cases:
  - Push and `read` together while empty: `count`=1 and `data_out` unchanged.
  - Push and `read` together while full: `count`=7, and the offered character is dropped with `overflow`=1.
- Assert `reset` asynchronously between clock edges with `count`=5: all outputs go to their reset values before the next edge, and subsequent pushes start at `mem[0]`.
